// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the rotation-mode CORDIC datapath.
// The ATAN table is also used by the vectoring-mode angle detector.
package cordic_pkg;

    localparam int N_STAGES  = 6;
    localparam int XY_W      = 10;
    localparam int Z_W       = 16;
    localparam int OUT_W     = 4;
    localparam int ANGLE_W   = 16;
    localparam int PHASE_W   = 9;
    localparam int X0        = 34;
    localparam int OUT_CLAMP = 7;

    // Fold boundaries in degrees.
    localparam int DEG_90  = 90;
    localparam int DEG_180 = 180;
    localparam int DEG_270 = 270;
    localparam int DEG_360 = 360;

    localparam int ATAN_TABLE [N_STAGES] = '{45, 27, 14, 7, 3, 2};

    typedef logic signed [XY_W-1:0]  xy_t;
    typedef logic signed [Z_W-1:0]   z_t;
    typedef logic signed [OUT_W-1:0] out_t;

    // Round-half-up by 8 followed by a symmetric clamp to +/-OUT_CLAMP.
    function automatic out_t round_sat(input xy_t v);
        logic signed [XY_W:0] sum;
        logic signed [XY_W:0] quot;
        int                   q;
        sum  = {v[XY_W-1], v};
        sum  = sum + (XY_W+1)'(4);
        quot = sum >>> 3;
        q    = int'(quot);
        if (q > OUT_CLAMP) begin
            return out_t'(OUT_CLAMP);
        end else if (q < -OUT_CLAMP) begin
            return out_t'(-OUT_CLAMP);
        end
        return out_t'(q);
    endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One registered CORDIC micro-rotation; the direction is chosen from the sign
// of the residual angle z, with z = 0 treated as positive.
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT    = 0,
    parameter int ATAN_DEG = 45
) (
    input  logic clock,
    input  logic reset,
    input  xy_t  x,
    input  xy_t  y,
    input  z_t   z,
    input  logic neg,
    input  logic valid,
    output xy_t  rot_x,
    output xy_t  rot_y,
    output z_t   rot_z,
    output logic rot_neg,
    output logic rot_valid
);

    xy_t  x_shift;
    xy_t  y_shift;
    z_t   atan_step;

    xy_t  x_reg;
    xy_t  y_reg;
    z_t   z_reg;
    logic neg_reg;
    logic valid_reg;

    assign x_shift   = x >>> SHIFT;
    assign y_shift   = y >>> SHIFT;
    assign atan_step = z_t'(ATAN_DEG);

    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            neg_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            neg_reg   <= neg;
            valid_reg <= valid;
            if (!z[Z_W-1]) begin
                x_reg <= x - y_shift;
                y_reg <= y + x_shift;
                z_reg <= z - atan_step;
            end else begin
                x_reg <= x + y_shift;
                y_reg <= y - x_shift;
                z_reg <= z + atan_step;
            end
        end
    end

    assign rot_x     = x_reg;
    assign rot_y     = y_reg;
    assign rot_z     = z_reg;
    assign rot_neg   = neg_reg;
    assign rot_valid = valid_reg;

endmodule

// File: rtl/cordic_rotator.sv
// Streaming rotation-mode CORDIC: integer-degree phase in, 4-bit I/Q out.
// Fold register, six micro-rotations, then a round/saturate output register.
module cordic_rotator
    import cordic_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic               i_valid,
    output out_t               o_I,
    output out_t               o_Q,
    output logic               o_valid
);

    logic [PHASE_W-1:0] a_raw;
    logic [PHASE_W-1:0] a_wrap;
    z_t                 a_ext;
    z_t                 z_fold;
    logic               neg_fold;
    logic               unused_angle_bits;

    xy_t  f_x_reg;
    xy_t  f_y_reg;
    z_t   f_z_reg;
    logic f_neg_reg;
    logic f_valid_reg;

    xy_t  x_stage     [0:N_STAGES];
    xy_t  y_stage     [0:N_STAGES];
    z_t   z_stage     [0:N_STAGES];
    logic neg_stage   [0:N_STAGES];
    logic valid_stage [0:N_STAGES];

    xy_t  x_final;
    xy_t  y_final;

    out_t i_reg;
    out_t q_reg;
    logic o_valid_reg;

    // Upper phase bits carry no information at 1-degree resolution.
    assign unused_angle_bits = &{1'b0, i_angle[ANGLE_W-1:PHASE_W]};

    // Fold the phase into [-90, +90] and remember whether a half-turn was removed.
    always_comb begin
        a_raw    = i_angle[PHASE_W-1:0];
        a_wrap   = a_raw;
        z_fold   = '0;
        neg_fold = 1'b0;
        if (a_raw >= PHASE_W'(DEG_360)) begin
            a_wrap = a_raw - PHASE_W'(DEG_360);
        end
        a_ext = z_t'({{(Z_W-PHASE_W){1'b0}}, a_wrap});
        if (a_wrap <= PHASE_W'(DEG_90)) begin
            z_fold = a_ext;
        end else if (a_wrap < PHASE_W'(DEG_270)) begin
            z_fold   = a_ext - z_t'(DEG_180);
            neg_fold = 1'b1;
        end else begin
            z_fold = a_ext - z_t'(DEG_360);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            f_x_reg     <= '0;
            f_y_reg     <= '0;
            f_z_reg     <= '0;
            f_neg_reg   <= 1'b0;
            f_valid_reg <= 1'b0;
        end else begin
            f_x_reg     <= xy_t'(X0);
            f_y_reg     <= '0;
            f_z_reg     <= z_fold;
            f_neg_reg   <= neg_fold;
            f_valid_reg <= i_valid;
        end
    end

    assign x_stage[0]     = f_x_reg;
    assign y_stage[0]     = f_y_reg;
    assign z_stage[0]     = f_z_reg;
    assign neg_stage[0]   = f_neg_reg;
    assign valid_stage[0] = f_valid_reg;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_rot
            cordic_rot_stage #(
                .SHIFT    (gi),
                .ATAN_DEG (ATAN_TABLE[gi])
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .x         (x_stage[gi]),
                .y         (y_stage[gi]),
                .z         (z_stage[gi]),
                .neg       (neg_stage[gi]),
                .valid     (valid_stage[gi]),
                .rot_x     (x_stage[gi+1]),
                .rot_y     (y_stage[gi+1]),
                .rot_z     (z_stage[gi+1]),
                .rot_neg   (neg_stage[gi+1]),
                .rot_valid (valid_stage[gi+1])
            );
        end
    endgenerate

    // Undo the half-turn fold by negating both components.
    always_comb begin
        x_final = x_stage[N_STAGES];
        y_final = y_stage[N_STAGES];
        if (neg_stage[N_STAGES]) begin
            x_final = -x_stage[N_STAGES];
            y_final = -y_stage[N_STAGES];
        end
    end

    // The residual angle of the last stage is not needed downstream.
    z_t unused_z_residual;
    assign unused_z_residual = z_stage[N_STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            i_reg       <= '0;
            q_reg       <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            o_valid_reg <= valid_stage[N_STAGES];
            if (valid_stage[N_STAGES]) begin
                i_reg <= round_sat(x_final);
                q_reg <= round_sat(y_final);
            end
        end
    end

    assign o_I     = i_reg;
    assign o_Q     = q_reg;
    assign o_valid = o_valid_reg;

endmodule

// File: tb/tb_cordic_rotator.sv
// Randomised and directed checks of cordic_rotator against a behavioural model
// of the fold / micro-rotation / round-saturate algorithm and its 8-cycle timing.
module tb_cordic_rotator;

    localparam int MAXN    = 1024;
    localparam int LATENCY = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [15:0]       i_angle;
    logic              i_valid;
    logic signed [3:0] o_I;
    logic signed [3:0] o_Q;
    logic              o_valid;

    always #5 clock = ~clock;

    cordic_rotator dut (
        .clock   (clock),
        .reset   (reset),
        .i_angle (i_angle),
        .i_valid (i_valid),
        .o_I     (o_I),
        .o_Q     (o_Q),
        .o_valid (o_valid)
    );

    logic              st_v [MAXN];
    logic [15:0]       st_a [MAXN];
    logic              st_r [MAXN];
    logic              ob_v [MAXN];
    logic signed [3:0] ob_i [MAXN];
    logic signed [3:0] ob_q [MAXN];
    logic              ex_v [MAXN];
    int                ex_i [MAXN];
    int                ex_q [MAXN];

    int n_stim;
    int n_run;
    int compared   = 0;
    int mismatched = 0;
    int hold_i     = 0;
    int hold_q     = 0;

    function automatic int wrap10(input int v);
        logic signed [9:0] t;
        t = v[9:0];
        return int'(t);
    endfunction

    function automatic int sat7(input int v);
        if (v > 7) return 7;
        if (v < -7) return -7;
        return v;
    endfunction

    // Reference: the algorithm in plain integer arithmetic.
    function automatic void golden(input logic [15:0] ang, output int ei, output int eq);
        int atan [6] = '{45, 27, 14, 7, 3, 2};
        int a, z, x, y, xn, yn;
        bit neg;
        a   = int'(ang[8:0]);
        if (a >= 360) a = a - 360;
        neg = 1'b0;
        if (a <= 90) z = a;
        else if (a < 270) begin z = a - 180; neg = 1'b1; end
        else z = a - 360;
        x = 34;
        y = 0;
        for (int i = 0; i < 6; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan[i];
            end else begin
                xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan[i];
            end
            x = wrap10(xn);
            y = wrap10(yn);
        end
        if (neg) begin x = -x; y = -y; end
        ei = sat7((x + 4) >>> 3);
        eq = sat7((y + 4) >>> 3);
    endfunction

    // Drives st_* for n_stim cycles plus LATENCY idle cycles, recording outputs.
    task automatic run_stim();
        n_run = n_stim + LATENCY;
        for (int t = n_stim; t < n_run; t++) begin
            st_v[t] = 1'b0; st_r[t] = 1'b0; st_a[t] = 16'(($urandom));
        end
        for (int t = 0; t < n_run; t++) begin
            @(posedge clock);
            #1;
            reset   = st_r[t];
            i_valid = st_v[t];
            i_angle = st_a[t];
            @(negedge clock);
            ob_v[t] = o_valid;
            ob_i[t] = o_I;
            ob_q[t] = o_Q;
        end
    endtask

    // Timing model: a sample issued in cycle j appears in cycle j+8 unless reset
    // is asserted in any of cycles j..j+7; the output pair holds otherwise.
    task automatic build_expected();
        int  j, ei, eq;
        bit  killed;
        for (int t = 0; t < n_run; t++) begin
            ex_v[t] = 1'b0;
            j = t - LATENCY;
            if (t > 0 && st_r[t-1]) begin
                hold_i = 0; hold_q = 0;
            end else if (j >= 0 && st_v[j]) begin
                killed = 1'b0;
                for (int k = j; k < t; k++) if (st_r[k]) killed = 1'b1;
                if (!killed) begin
                    golden(st_a[j], ei, eq);
                    hold_i  = ei; hold_q = eq;
                    ex_v[t] = 1'b1;
                end
            end
            ex_i[t] = hold_i;
            ex_q[t] = hold_q;
        end
    endtask

    task automatic test_reset();
        n_stim = 3;
        for (int t = 0; t < 3; t++) begin
            st_r[t] = 1'b1; st_v[t] = 1'b1; st_a[t] = 16'($urandom_range(0, 359));
        end
        run_stim();
        build_expected();
        for (int t = 0; t < n_run; t++) begin
            $display("reset    t=%0d valid=%0b I=%0d Q=%0d", t, ob_v[t], ob_i[t], ob_q[t]);
            compared++;
            if (ob_v[t] !== 1'b0 || ob_i[t] !== 4'sd0 || ob_q[t] !== 4'sd0) begin
                mismatched++;
                $display("FAIL reset_state t=%0d got v=%0b I=%0d Q=%0d want v=0 I=0 Q=0",
                         t, ob_v[t], ob_i[t], ob_q[t]);
            end
        end
    endtask

    task automatic test_cardinal();
        int ang [4] = '{0, 90, 180, 270};
        int wi  [4] = '{7, 0, -7, 0};
        int wq  [4] = '{0, 7, 0, -7};
        n_stim = 5;
        for (int k = 0; k < 4; k++) begin
            st_r[k] = 1'b0; st_v[k] = 1'b1; st_a[k] = 16'(ang[k]);
        end
        st_r[4] = 1'b0; st_v[4] = 1'b0; st_a[4] = 16'd0;
        run_stim();
        build_expected();
        compared++;
        if (ob_v[LATENCY-1] !== 1'b0) begin
            mismatched++;
            $display("FAIL cardinal_early got valid=%0b want 0", ob_v[LATENCY-1]);
        end
        for (int k = 0; k < 4; k++) begin
            $display("cardinal ang=%0d valid=%0b I=%0d Q=%0d", ang[k],
                     ob_v[k+LATENCY], ob_i[k+LATENCY], ob_q[k+LATENCY]);
            compared++;
            if (ob_v[k+LATENCY] !== 1'b1 || ob_i[k+LATENCY] !== wi[k] || ob_q[k+LATENCY] !== wq[k]) begin
                mismatched++;
                $display("FAIL cardinal ang=%0d got v=%0b I=%0d Q=%0d want v=1 I=%0d Q=%0d", ang[k],
                         ob_v[k+LATENCY], ob_i[k+LATENCY], ob_q[k+LATENCY], wi[k], wq[k]);
            end
        end
        compared++;
        if (ob_v[LATENCY+4] !== 1'b0) begin
            mismatched++;
            $display("FAIL cardinal_late got valid=%0b want 0", ob_v[LATENCY+4]);
        end
    endtask

    task automatic test_diag_wrap();
        logic [15:0] ang [3] = '{16'd45, 16'd450, 16'hFE00};
        int          wi  [3] = '{5, 0, 7};
        int          wq  [3] = '{5, 7, 0};
        n_stim = 3;
        for (int k = 0; k < 3; k++) begin
            st_r[k] = 1'b0; st_v[k] = 1'b1; st_a[k] = ang[k];
        end
        run_stim();
        build_expected();
        for (int k = 0; k < 3; k++) begin
            $display("diag     ang=0x%04h valid=%0b I=%0d Q=%0d", ang[k],
                     ob_v[k+LATENCY], ob_i[k+LATENCY], ob_q[k+LATENCY]);
            compared++;
            if (ob_v[k+LATENCY] !== 1'b1 || ob_i[k+LATENCY] !== wi[k] || ob_q[k+LATENCY] !== wq[k]) begin
                mismatched++;
                $display("FAIL diag_wrap ang=0x%04h got v=%0b I=%0d Q=%0d want v=1 I=%0d Q=%0d", ang[k],
                         ob_v[k+LATENCY], ob_i[k+LATENCY], ob_q[k+LATENCY], wi[k], wq[k]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic pat_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   wi    [4] = '{7, 7, 7, -7};
        n_stim = 44;
        for (int t = 0; t < n_stim; t++) begin
            st_r[t] = 1'b0;
            st_v[t] = ($urandom_range(0, 2) != 0);
            st_a[t] = 16'($urandom);
        end
        for (int k = 0; k < 4; k++) st_v[k] = pat_v[k];
        st_a[0] = 16'd0;
        st_a[3] = 16'd180;
        run_stim();
        build_expected();
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (ob_v[k+LATENCY] !== pat_v[k] || ob_i[k+LATENCY] !== wi[k] || ob_q[k+LATENCY] !== 4'sd0) begin
                mismatched++;
                $display("FAIL bubble_hold k=%0d got v=%0b I=%0d Q=%0d want v=%0b I=%0d Q=0", k,
                         ob_v[k+LATENCY], ob_i[k+LATENCY], ob_q[k+LATENCY], pat_v[k], wi[k]);
            end
        end
        for (int t = 0; t < n_run; t++) begin
            if (ob_v[t]) $display("bubbles  t=%0d I=%0d Q=%0d", t, ob_i[t], ob_q[t]);
            compared++;
            if (ob_v[t] !== ex_v[t] || ob_i[t] !== ex_i[t] || ob_q[t] !== ex_q[t]) begin
                mismatched++;
                $display("FAIL bubbles t=%0d got v=%0b I=%0d Q=%0d want v=%0b I=%0d Q=%0d",
                         t, ob_v[t], ob_i[t], ob_q[t], ex_v[t], ex_i[t], ex_q[t]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int ei, eq;
        n_stim = 8;
        for (int t = 0; t < n_stim; t++) begin
            st_r[t] = (t == 4); st_v[t] = 1'b1; st_a[t] = 16'(t);
        end
        run_stim();
        build_expected();
        for (int t = 5; t < 5 + LATENCY; t++) begin
            compared++;
            if (ob_v[t] !== 1'b0) begin
                mismatched++;
                $display("FAIL midreset_flush t=%0d got valid=%0b want 0", t, ob_v[t]);
            end
        end
        golden(16'd5, ei, eq);
        compared++;
        if (ob_v[13] !== 1'b1 || ob_i[13] !== ei || ob_q[13] !== eq) begin
            mismatched++;
            $display("FAIL midreset_first got v=%0b I=%0d Q=%0d want v=1 I=%0d Q=%0d",
                     ob_v[13], ob_i[13], ob_q[13], ei, eq);
        end
        for (int t = 0; t < n_run; t++) begin
            $display("midreset t=%0d valid=%0b I=%0d Q=%0d", t, ob_v[t], ob_i[t], ob_q[t]);
            compared++;
            if (ob_v[t] !== ex_v[t] || ob_i[t] !== ex_i[t] || ob_q[t] !== ex_q[t]) begin
                mismatched++;
                $display("FAIL midreset t=%0d got v=%0b I=%0d Q=%0d want v=%0b I=%0d Q=%0d",
                         t, ob_v[t], ob_i[t], ob_q[t], ex_v[t], ex_i[t], ex_q[t]);
            end
        end
    endtask

    task automatic test_sweep();
        n_stim = 360;
        for (int t = 0; t < n_stim; t++) begin
            st_r[t] = 1'b0; st_v[t] = 1'b1; st_a[t] = 16'(t);
        end
        run_stim();
        build_expected();
        for (int t = 0; t < n_run; t++) begin
            if (ob_v[t]) begin
                $display("sweep    ang=%0d I=%0d Q=%0d", t - LATENCY, ob_i[t], ob_q[t]);
                compared++;
                if (ob_i[t] > 4'sd7 || ob_i[t] < -4'sd7 || ob_q[t] > 4'sd7 || ob_q[t] < -4'sd7) begin
                    mismatched++;
                    $display("FAIL sweep_range t=%0d got I=%0d Q=%0d want within +/-7", t, ob_i[t], ob_q[t]);
                end
            end
            compared++;
            if (ob_v[t] !== ex_v[t] || ob_i[t] !== ex_i[t] || ob_q[t] !== ex_q[t]) begin
                mismatched++;
                $display("FAIL sweep t=%0d got v=%0b I=%0d Q=%0d want v=%0b I=%0d Q=%0d",
                         t, ob_v[t], ob_i[t], ob_q[t], ex_v[t], ex_i[t], ex_q[t]);
            end
        end
    endtask

    task automatic test_random();
        n_stim = 400;
        for (int t = 0; t < n_stim; t++) begin
            st_r[t] = ($urandom_range(0, 39) == 0);
            st_v[t] = ($urandom_range(0, 3) != 0);
            st_a[t] = 16'($urandom);
        end
        run_stim();
        build_expected();
        for (int t = 0; t < n_run; t++) begin
            if (ob_v[t]) $display("random   t=%0d I=%0d Q=%0d", t, ob_i[t], ob_q[t]);
            compared++;
            if (ob_v[t] !== ex_v[t] || ob_i[t] !== ex_i[t] || ob_q[t] !== ex_q[t]) begin
                mismatched++;
                $display("FAIL random t=%0d got v=%0b I=%0d Q=%0d want v=%0b I=%0d Q=%0d",
                         t, ob_v[t], ob_i[t], ob_q[t], ex_v[t], ex_i[t], ex_q[t]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_angle = 16'd0;
        test_reset();
        test_cardinal();
        test_diag_wrap();
        test_bubbles();
        test_reset_midstream();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
